// File: rtl/capture_sequencer_pkg.sv
// Shared state encoding and defaults for the capture burst sequencer.
// Optional ARMED-state trigger timeout is compiled in with CAPTURE_SEQ_TIMEOUT_EN.
package capture_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam int CNT_W_DEF = 16;
  localparam int TMO_W_DEF = 24;

  function automatic logic is_busy(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/capture_sequencer_seq_timer.sv
// Loadable down-counter with zero flag; load wins over decrement and the
// count saturates at zero instead of wrapping.
module seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         ena,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (ena && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Triggered capture burst sequencer: arm -> trigger -> pre-delay -> capture -> holdoff.
// Define CAPTURE_SEQ_TIMEOUT_EN to enable the trigger wait timeout in ARMED.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_length,
  input  logic [CNT_W-1:0] cfg_holdoff,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             in_valid,
  output logic             cap_valid,
  output logic [CNT_W-1:0] sample_idx,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   delay_reg, length_reg, holdoff_reg, idx_reg;
  logic               done_reg, done_next;
  logic               aborted_reg, aborted_next;
  logic               cfg_load;
  logic               tmr_load, tmr_ena, tmr_zero;
  logic [CNT_W-1:0]   tmr_val;
  logic               last_sample;
  logic               tmo_expire;

  // Timer values are loaded as N-1 so the zero flag marks the last of N cycles.
  seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .ena      (tmr_ena),
    .zero     (tmr_zero)
  );

`ifdef CAPTURE_SEQ_TIMEOUT_EN
  logic tmo_en_reg;
  logic tmo_zero;

  seq_timer #(.W(TMO_W)) u_tmo_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cfg_load),
    .load_val (cfg_timeout - 1'b1),
    .ena      (state_reg == ST_ARMED),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_en_reg <= 1'b0;
    end else if (cfg_load) begin
      tmo_en_reg <= (cfg_timeout != '0);
    end
  end

  assign tmo_expire = tmo_en_reg & tmo_zero;
`else
  logic unused_tmo;
  assign unused_tmo = ^cfg_timeout;
  assign tmo_expire = 1'b0;
`endif

  assign cap_valid  = in_valid & (state_reg == ST_CAPTURE) & (length_reg != '0);
  assign sample_idx = idx_reg;
  assign busy       = is_busy(state_reg);
  assign done       = done_reg;
  assign aborted    = aborted_reg;

  always_comb begin
    state_next   = state_reg;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    cfg_load     = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_ena      = 1'b0;
    last_sample  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (arm) begin
          cfg_load   = 1'b1;
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (trig) begin
          if (delay_reg == '0) begin
            state_next = ST_CAPTURE;
          end else begin
            state_next = ST_DELAY;
            tmr_load   = 1'b1;
            tmr_val    = delay_reg - 1'b1;
          end
        end else if (tmo_expire) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
        end
      end
      ST_DELAY: begin
        tmr_ena = 1'b1;
        if (tmr_zero) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (length_reg == '0 || (in_valid && idx_reg == length_reg - 1'b1))
          last_sample = 1'b1;
      end
      ST_HOLDOFF: begin
        tmr_ena = 1'b1;
        if (tmr_zero) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (last_sample) begin
      if (holdoff_reg == '0) begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = ST_HOLDOFF;
        tmr_load   = 1'b1;
        tmr_val    = holdoff_reg - 1'b1;
      end
    end

    // Abort overrides any completion decided above in the same cycle.
    if (abort && state_reg != ST_IDLE) begin
      state_next   = ST_IDLE;
      done_next    = 1'b0;
      aborted_next = 1'b1;
      tmr_load     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      delay_reg   <= '0;
      length_reg  <= '0;
      holdoff_reg <= '0;
      idx_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
      if (cfg_load) begin
        delay_reg   <= cfg_delay;
        length_reg  <= cfg_length;
        holdoff_reg <= cfg_holdoff;
      end
      if (cfg_load || state_next == ST_IDLE) begin
        idx_reg <= '0;
      end else if (cap_valid) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: builds each burst's expected
// per-cycle timeline from the delay/length/holdoff rules and compares outputs.
module tb_capture_sequencer;

  localparam int NC = 128;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        abort;
  logic        trig;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_length;
  logic [15:0] cfg_holdoff;
  logic [23:0] cfg_timeout;
  logic        in_valid;
  logic        cap_valid;
  logic [15:0] sample_idx;
  logic        busy;
  logic        done;
  logic        aborted;

  int n_chk  = 0;
  int n_fail = 0;

  capture_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .abort       (abort),
    .trig        (trig),
    .cfg_delay   (cfg_delay),
    .cfg_length  (cfg_length),
    .cfg_holdoff (cfg_holdoff),
    .cfg_timeout (cfg_timeout),
    .in_valid    (in_valid),
    .cap_valid   (cap_valid),
    .sample_idx  (sample_idx),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k=0 is the arm cycle; ARMED spans 1..1+w with trig at 1+w, then d delay
  // cycles, then capture until len valid samples, then hold cycles, then done.
  task automatic run_burst(input int d, input int len, input int hold, input int w,
                           input int abort_at, input int rst_at, input int vmode);
    logic vld [NC];
    logic e_busy [NC];
    logic e_cv [NC];
    logic e_done [NC];
    logic e_ab [NC];
    logic c_idx [NC];
    int   e_idx [NC];
    int   c0, cnt, cap_end, e, last, k;

    c0 = 2 + w + d;
    for (int i = 0; i < NC; i++) begin
      e_busy[i] = 1'b0; e_cv[i] = 1'b0; e_done[i] = 1'b0; e_ab[i] = 1'b0;
      c_idx[i] = 1'b0;  e_idx[i] = 0;
      if (i < c0)          vld[i] = 1'($urandom_range(0, 1));
      else if (vmode == 0) vld[i] = 1'b1;
      else if (vmode == 1) vld[i] = ((i - c0) % 2 == 0);
      else                 vld[i] = (i >= c0 + 20) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    c_idx[0] = 1'b1;
    for (int i = 1; i < c0; i++) begin
      e_busy[i] = 1'b1;
      c_idx[i]  = 1'b1;
    end
    cap_end = c0;
    if (len > 0) begin
      cnt = 0;
      k   = c0;
      while (cnt < len) begin
        e_busy[k] = 1'b1;
        c_idx[k]  = 1'b1;
        e_idx[k]  = cnt;
        e_cv[k]   = vld[k];
        if (vld[k]) cnt++;
        cap_end = k;
        k++;
      end
    end else begin
      e_busy[c0] = 1'b1;
      c_idx[c0]  = 1'b1;
    end
    e = cap_end + hold;
    for (int i = cap_end + 1; i <= e; i++) e_busy[i] = 1'b1;
    last = e + 1;
    e_done[last] = 1'b1;
    c_idx[last]  = 1'b1;
    if (abort_at >= 1 && abort_at <= e) begin
      last = abort_at + 1;
      e_busy[last] = 1'b0; e_cv[last] = 1'b0; e_done[last] = 1'b0;
      e_ab[last]   = 1'b1; c_idx[last] = 1'b1; e_idx[last] = 0;
    end

    for (k = 0; k <= last; k++) begin
      arm   = (k == 0) ? 1'b1 : ((k < last) ? 1'($urandom_range(0, 1)) : 1'b0);
      abort = (k == 0) ? 1'($urandom_range(0, 1)) : (k == abort_at);
      if (k >= 1 && k <= w) trig = 1'b0;
      else if (k == 1 + w)  trig = 1'b1;
      else                  trig = 1'($urandom_range(0, 1));
      in_valid    = vld[k];
      cfg_delay   = (k == 0) ? 16'(d)    : 16'($urandom);
      cfg_length  = (k == 0) ? 16'(len)  : 16'($urandom);
      cfg_holdoff = (k == 0) ? 16'(hold) : 16'($urandom);
      cfg_timeout = (k == 0) ? 24'd0     : 24'($urandom_range(1, 3));
      if (rst_at > 0 && k == rst_at) begin
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst_busy", k, 32'(busy), 0);
        chk("rst_cap_valid", k, 32'(cap_valid), 0);
        chk("rst_idx", k, 32'(sample_idx), 0);
        chk("rst_done", k, 32'(done), 0);
        chk("rst_aborted", k, 32'(aborted), 0);
        tick();
        rst_n = 1'b1;
        arm   = 1'b0;
        abort = 1'b0;
        tick();
        return;
      end
      #1;
      chk("busy", k, 32'(busy), 32'(e_busy[k]));
      chk("done", k, 32'(done), 32'(e_done[k]));
      chk("aborted", k, 32'(aborted), 32'(e_ab[k]));
      chk("cap_valid", k, 32'(cap_valid), 32'(e_cv[k]));
      if (c_idx[k]) chk("sample_idx", k, 32'(sample_idx), 32'(e_idx[k]));
      tick();
    end
    arm   = 1'b0;
    abort = 1'b0;
    $display("burst d=%0d len=%0d hold=%0d w=%0d abort_at=%0d vmode=%0d cycles=%0d",
             d, len, hold, w, abort_at, vmode, last + 1);
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0; in_valid = 1'b1;
    cfg_delay = '0; cfg_length = '0; cfg_holdoff = '0; cfg_timeout = '0;
    #3;
    chk("reset_busy", 0, 32'(busy), 0);
    chk("reset_cap_valid", 0, 32'(cap_valid), 0);
    chk("reset_idx", 0, 32'(sample_idx), 0);
    chk("reset_done", 0, 32'(done), 0);
    chk("reset_aborted", 0, 32'(aborted), 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_burst(3, 4, 2, 0, 0, 0, 0);   // nominal burst
    run_burst(1, 3, 1, 1, 0, 0, 1);   // alternating in_valid
    run_burst(0, 0, 0, 0, 0, 0, 0);   // all-zero config
    run_burst(1, 8, 2, 0, 5, 0, 0);   // abort at idx 2
    run_burst(2, 2, 1, 0, 0, 0, 0);   // re-arm after abort
    run_burst(0, 2, 2, 0, 3, 0, 0);   // abort with final sample
    run_burst(0, 8, 1, 0, 0, 5, 0);   // async reset mid-capture
    run_burst(0, 5, 0, 2, 0, 0, 2);

    for (int n = 0; n < 40; n++) begin
      run_burst($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 3),
                $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0,
                0, 2);
    end

    trig = 1'b0; in_valid = 1'b0; cfg_timeout = 24'd5;
    arm = 1'b1;
    tick();
    arm = 1'b0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      chk("tmo_busy", k, 32'(busy), 1);
      tick();
    end
    chk("tmo_busy_end", 6, 32'(busy), 0);
    chk("tmo_aborted", 6, 32'(aborted), 1);
    tick();
    cfg_timeout = 24'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 1100; k++) tick();
    chk("notmo_busy", 1100, 32'(busy), 1);
`else
    for (int k = 0; k < 20; k++) tick();
    chk("notmo_busy", 20, 32'(busy), 1);
    chk("notmo_aborted", 20, 32'(aborted), 0);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wait_abort_busy", 0, 32'(busy), 0);
    chk("wait_abort_pulse", 0, 32'(aborted), 1);
    $display("trigger wait check complete");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
